// File: rtl/dht11_reader.sv
// +------------------------------------------------------------------------+
// | dht11_reader: DHT-11 single-wire reader, checksum check, BCD output    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module dht11_reader #(
   parameter int CLK_FREQ_HZ   = 100_000_000,
   parameter int START_LOW_US  = 18000,
   parameter int BIT_THRESH_US = 40,
   parameter int TIMEOUT_US    = 200
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic        start,
   input  logic        dht_in,
   output logic        dht_oe,
   output logic        busy,
   output logic [31:0] data_out,
   output logic        data_valid,
   output logic        err
);

   localparam int c_tick_div = (CLK_FREQ_HZ / 1_000_000 < 1) ? 1 : CLK_FREQ_HZ / 1_000_000;
   localparam int c_tick_w   = (c_tick_div > 1) ? $clog2(c_tick_div) : 1;

   localparam logic [c_tick_w-1:0] c_tick_last  = c_tick_w'(c_tick_div - 1);
   localparam logic [15:0]         c_start_low  = 16'(START_LOW_US);
   localparam logic [15:0]         c_bit_thresh = 16'(BIT_THRESH_US);
   localparam logic [15:0]         c_timeout    = 16'(TIMEOUT_US);
   localparam logic [5:0]          c_last_bit   = 6'd39;

   localparam logic [3:0] c_st_idle      = 4'd0;
   localparam logic [3:0] c_st_start_low = 4'd1;
   localparam logic [3:0] c_st_rel       = 4'd2;
   localparam logic [3:0] c_st_resp_l    = 4'd3;
   localparam logic [3:0] c_st_resp_h    = 4'd4;
   localparam logic [3:0] c_st_bit_l     = 4'd5;
   localparam logic [3:0] c_st_bit_h     = 4'd6;
   localparam logic [3:0] c_st_check     = 4'd7;
   localparam logic [3:0] c_st_conv      = 4'd8;
   localparam logic [3:0] c_st_err       = 4'd9;

   logic                sync1_q, sync2_q;
   logic [3:0]          state_q, state_d;
   logic [c_tick_w-1:0] tick_cnt_q, tick_cnt_d;
   logic [15:0]         us_q, us_d;
   logic [5:0]          bit_cnt_q, bit_cnt_d;
   logic [39:0]         shift_q, shift_d;
   logic                seen_high_q, seen_high_d;
   logic [31:0]         data_q, data_d;
   logic                dht_oe_q, dht_oe_d;
   logic                busy_q, busy_d;
   logic                valid_q, valid_d;
   logic                err_q, err_d;

   logic                w_line;
   logic                w_tick;
   logic                w_state_chg;
   logic                w_timeout;
   logic                w_bit;
   logic [15:0]         w_us_next;
   logic [7:0]          w_sum;

   // Values above 99 cannot be shown on two digits, so they saturate at 99.
   function automatic logic [7:0] to_bcd(input logic [7:0] v);
      logic [3:0] tens;
      logic [7:0] rem;
      tens = 4'd0;
      rem  = v;
      if (v > 8'd99) begin
         return 8'h99;
      end
      for (int i = 0; i < 9; i++) begin
         if (rem >= 8'd10) begin
            rem  = rem - 8'd10;
            tens = tens + 4'd1;
         end
      end
      return {tens, 4'd0} | rem;
   endfunction

   assign w_line    = sync2_q;
   assign w_tick    = (tick_cnt_q == c_tick_last);
   assign w_us_next = (w_tick && (us_q != 16'hFFFF)) ? us_q + 16'd1 : us_q;
   assign w_timeout = (w_us_next >= c_timeout);
   assign w_bit     = (w_us_next > c_bit_thresh);
   assign w_sum     = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      data_d      = data_q;
      seen_high_d = seen_high_q;

      case (state_q)
         c_st_idle: begin
            if (start) state_d = c_st_start_low;
         end
         c_st_start_low: begin
            if (w_us_next >= c_start_low) state_d = c_st_rel;
         end
         c_st_rel: begin
            // The synchronizer still holds our own low pulse right after release,
            // so the sensor response only counts once the line was seen high.
            if (w_line) seen_high_d = 1'b1;
            if (seen_high_q && !w_line) state_d = c_st_resp_l;
            else if (w_timeout)         state_d = c_st_err;
         end
         c_st_resp_l: begin
            if (w_line)         state_d = c_st_resp_h;
            else if (w_timeout) state_d = c_st_err;
         end
         c_st_resp_h: begin
            if (!w_line) begin
               state_d   = c_st_bit_l;
               bit_cnt_d = 6'd0;
            end else if (w_timeout) begin
               state_d = c_st_err;
            end
         end
         c_st_bit_l: begin
            if (w_line)         state_d = c_st_bit_h;
            else if (w_timeout) state_d = c_st_err;
         end
         c_st_bit_h: begin
            if (!w_line) begin
               shift_d   = {shift_q[38:0], w_bit};
               bit_cnt_d = bit_cnt_q + 6'd1;
               state_d   = (bit_cnt_q == c_last_bit) ? c_st_check : c_st_bit_l;
            end else if (w_timeout) begin
               state_d = c_st_err;
            end
         end
         c_st_check: begin
            if (w_sum == shift_q[7:0]) begin
               state_d = c_st_conv;
               data_d  = {shift_q[31:24], to_bcd(shift_q[39:32]),
                          shift_q[15:8],  to_bcd(shift_q[23:16])};
            end else begin
               state_d = c_st_err;
            end
         end
         c_st_conv: state_d = c_st_idle;
         c_st_err:  state_d = c_st_idle;
         default:   state_d = c_st_idle;
      endcase

      w_state_chg = (state_d != state_q);
      if (w_state_chg) seen_high_d = 1'b0;

      tick_cnt_d = (w_state_chg || w_tick) ? '0 : tick_cnt_q + 1'b1;
      us_d       = w_state_chg ? 16'd0 : w_us_next;

      dht_oe_d = (state_d == c_st_start_low);
      busy_d   = (state_d != c_st_idle) && (state_d != c_st_conv) && (state_d != c_st_err);
      valid_d  = (state_d == c_st_conv);
      err_d    = (state_d == c_st_err);
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         state_q     <= c_st_idle;
         tick_cnt_q  <= '0;
         us_q        <= 16'd0;
         bit_cnt_q   <= 6'd0;
         shift_q     <= 40'd0;
         seen_high_q <= 1'b0;
         data_q      <= 32'd0;
         dht_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         sync1_q     <= dht_in;
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         us_q        <= us_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         seen_high_q <= seen_high_d;
         data_q      <= data_d;
         dht_oe_q    <= dht_oe_d;
         busy_q      <= busy_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
      end
   end

   assign dht_oe     = dht_oe_q;
   assign busy       = busy_q;
   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dht11_reader.sv
// +------------------------------------------------------------------------+
// | tb_dht11_reader: randomized DHT-11 sensor model with reference checks  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_dht11_reader;

   localparam int c_start_low = 20;
   localparam int c_timeout   = 200;
   localparam int c_thresh    = 40;

   localparam int c_mode_normal = 0;
   localparam int c_mode_stuck  = 1;
   localparam int c_mode_poke   = 2;
   localparam int c_mode_reset  = 3;

   logic        clk_in = 1'b0;
   logic        rst;
   logic        start;
   logic        sensor;
   logic        dht_in;
   logic        dht_oe;
   logic        busy;
   logic [31:0] data_out;
   logic        data_valid;
   logic        err;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc = 0, valid_cnt = 0, err_cnt = 0, oe_rises = 0;
   int          oe_len = 0, oe_len_last = 0, rel_cyc = 0, err_cyc = 0;
   logic        oe_prev = 1'b0;
   int          hi_w[40];
   logic [31:0] exp_data;

   // Open-drain line: low while the reader drives, otherwise the sensor level.
   assign dht_in = dht_oe ? 1'b0 : sensor;

   dht11_reader #(
      .CLK_FREQ_HZ  (1_000_000),
      .START_LOW_US (c_start_low),
      .BIT_THRESH_US(c_thresh),
      .TIMEOUT_US   (c_timeout)
   ) u_dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .start     (start),
      .dht_in    (dht_in),
      .dht_oe    (dht_oe),
      .busy      (busy),
      .data_out  (data_out),
      .data_valid(data_valid),
      .err       (err)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) begin
      cyc = cyc + 1;
      if (dht_oe && !oe_prev) oe_rises = oe_rises + 1;
      if (dht_oe) begin
         oe_len = oe_len + 1;
      end else if (oe_len != 0) begin
         oe_len_last = oe_len;
         oe_len      = 0;
         rel_cyc     = cyc;
      end
      oe_prev = dht_oe;
      if (data_valid) valid_cnt = valid_cnt + 1;
      if (err) begin
         err_cnt = err_cnt + 1;
         err_cyc = cyc;
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (obs !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: decode bits from the high widths actually driven.
   function automatic logic [39:0] model_decode();
      logic [39:0] d;
      for (int i = 0; i < 40; i++) d[39-i] = (hi_w[i] > c_thresh);
      return d;
   endfunction

   function automatic bit model_ok(input logic [39:0] d);
      int s;
      s = int'(d[39:32]) + int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8]);
      return (s % 256) == int'(d[7:0]);
   endfunction

   function automatic logic [7:0] model_bcd(input int v);
      if (v > 99) return 8'h99;
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   function automatic logic [31:0] model_word(input logic [39:0] d);
      return {d[31:24], model_bcd(int'(d[39:32])), d[15:8], model_bcd(int'(d[23:16]))};
   endfunction

   task automatic set_widths(input logic [39:0] f, input bit edge_style);
      for (int i = 0; i < 40; i++) begin
         if (f[39-i]) hi_w[i] = edge_style ? 41 : int'($urandom_range(41, 75));
         else         hi_w[i] = edge_style ? 40 : int'($urandom_range(18, 40));
      end
   endtask

   task automatic make_frame(output logic [39:0] f, input bit good);
      logic [7:0] b4, b3, b2, b1, s;
      b4 = 8'($urandom_range(0, 255));
      b3 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      b1 = 8'($urandom_range(0, 255));
      s  = b4 + b3 + b2 + b1;
      if (!good) s = s ^ 8'(1 << $urandom_range(0, 7));
      f = {b4, b3, b2, b1, s};
   endtask

   task automatic pulse_start();
      @(negedge clk_in) start = 1'b1;
      @(negedge clk_in) start = 1'b0;
   endtask

   task automatic sensor_frame(input int mode, input int k);
      int n;
      int lo;
      n = 0;
      while (!dht_oe && n < 50) begin @(negedge clk_in); n++; end
      if (!dht_oe) begin check("oe_rise", 32'd0, 32'd1); return; end
      n = 0;
      while (dht_oe && n < 100) begin @(negedge clk_in); n++; end
      if (dht_oe) begin check("oe_fall", 32'd1, 32'd0); return; end
      sensor = 1'b1; repeat (30) @(negedge clk_in);
      sensor = 1'b0; repeat (80) @(negedge clk_in);
      sensor = 1'b1; repeat (80) @(negedge clk_in);
      for (int i = 0; i < 40; i++) begin
         lo     = int'($urandom_range(30, 55));
         sensor = 1'b0;
         if (mode == c_mode_stuck && i == k) begin
            repeat (260) @(negedge clk_in);
            sensor = 1'b1;
            return;
         end
         if (mode == c_mode_poke && i == k) begin
            pulse_start();
            repeat (lo - 2) @(negedge clk_in);
         end else begin
            repeat (lo) @(negedge clk_in);
         end
         sensor = 1'b1;
         if (mode == c_mode_reset && i == k) begin
            repeat (10) @(negedge clk_in);
            rst = 1'b1;
            @(negedge clk_in);
            check("rst_oe", 32'(dht_oe), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_data", data_out, 32'd0);
            check("rst_valid", 32'(data_valid), 32'd0);
            check("rst_err", 32'(err), 32'd0);
            rst = 1'b0;
            return;
         end
         repeat (hi_w[i]) @(negedge clk_in);
      end
      sensor = 1'b0; repeat (50) @(negedge clk_in);
      sensor = 1'b1;
   endtask

   task automatic run_read(input string tag, input int mode, input int k);
      int          v0, e0, r0;
      logic [39:0] d;
      bit          ok;
      v0 = valid_cnt; e0 = err_cnt; r0 = oe_rises;
      pulse_start();
      sensor_frame(mode, k);
      repeat (10) @(negedge clk_in);
      if (mode == c_mode_reset) begin
         exp_data = 32'd0;
         check({tag, "_valid"}, 32'(valid_cnt - v0), 32'd0);
         check({tag, "_err"}, 32'(err_cnt - e0), 32'd0);
         check({tag, "_data"}, data_out, exp_data);
         return;
      end
      check({tag, "_oe_len"}, 32'(oe_len_last), 32'(c_start_low));
      check({tag, "_oe_rises"}, 32'(oe_rises - r0), 32'd1);
      if (mode == c_mode_stuck) begin
         check({tag, "_err"}, 32'(err_cnt - e0), 32'd1);
         check({tag, "_valid"}, 32'(valid_cnt - v0), 32'd0);
      end else begin
         d  = model_decode();
         ok = model_ok(d);
         if (ok) exp_data = model_word(d);
         check({tag, "_valid"}, 32'(valid_cnt - v0), ok ? 32'd1 : 32'd0);
         check({tag, "_err"}, 32'(err_cnt - e0), ok ? 32'd0 : 32'd1);
      end
      check({tag, "_data"}, data_out, exp_data);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [39:0] f;
      int          v0, e0, n;

      rst = 1'b1; start = 1'b0; sensor = 1'b1;
      repeat (5) @(negedge clk_in);
      check("reset_oe", 32'(dht_oe), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_data", data_out, 32'd0);
      check("reset_valid", 32'(data_valid), 32'd0);
      check("reset_err", 32'(err), 32'd0);
      rst = 1'b0;
      exp_data = 32'd0;
      repeat (5) @(negedge clk_in);

      f = {8'd45, 8'd0, 8'd27, 8'd0, 8'd72};
      set_widths(f, 1'b0);
      run_read("good", c_mode_normal, 0);
      check("good_word", data_out, 32'h0045_0027);

      f = {8'd45, 8'd0, 8'd27, 8'd0, 8'd73};
      set_widths(f, 1'b0);
      run_read("chkerr", c_mode_normal, 0);
      check("chkerr_keep", data_out, 32'h0045_0027);

      make_frame(f, 1'b1);
      set_widths(f, 1'b1);
      run_read("edge", c_mode_normal, 0);

      v0 = valid_cnt; e0 = err_cnt;
      pulse_start();
      n = 0;
      while (err_cnt == e0 && n < 500) begin @(negedge clk_in); n++; end
      check("absent_err", 32'(err_cnt - e0), 32'd1);
      check("absent_time", 32'(err_cyc - rel_cyc), 32'(c_timeout));
      check("absent_valid", 32'(valid_cnt - v0), 32'd0);
      check("absent_busy", 32'(busy), 32'd0);
      repeat (5) @(negedge clk_in);

      make_frame(f, 1'b1);
      set_widths(f, 1'b0);
      run_read("stuck", c_mode_stuck, 17);

      make_frame(f, 1'b1);
      set_widths(f, 1'b0);
      run_read("after_stuck", c_mode_normal, 0);

      f = {8'd120, 8'd5, 8'd30, 8'd9, 8'd164};
      set_widths(f, 1'b0);
      run_read("clamp_poke", c_mode_poke, 10);
      check("clamp_hum", 32'(data_out[23:16]), 32'h99);

      make_frame(f, 1'b1);
      set_widths(f, 1'b0);
      run_read("rst_bith", c_mode_reset, 22);

      for (int t = 0; t < 6; t++) begin
         make_frame(f, ($urandom_range(0, 3) != 0));
         set_widths(f, ($urandom_range(0, 2) == 0));
         run_read("rand", c_mode_normal, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
